id_stage: RTL

Decode stage of the Jala 5-stage rv32i pipeline, directly downstream of instruction fetch. Registers the fetched word, decodes it, reads the register file and generates the immediate. Detects load-use hazards against the instruction it issued last cycle, producing a stall back to fetch. Drives the ID/EX pipeline register consumed by execute, and owns the architectural register file, written by writeback.

---
 rtl/jala_pkg.sv | 73 +++++++
 rtl/id_stage_if.sv | 39 +++
 rtl/jala_regfile.sv | 42 ++++
 rtl/id_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/jala_pkg.sv
// rtl/jala_pkg.sv - Jala rv32i opcodes, ALU operations, ID/EX bundle and immediate helpers.
package jala_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic        reg_wr;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        illegal;
  } id_ex_t;

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - ID/EX pipeline register bundle; master drives it (decode), slave consumes it (execute).
interface id_stage_if;
  import jala_pkg::*;

  logic        op_ex_valid;
  logic [31:0] op_ex_pc;
  logic [31:0] op_ex_rs1_val;
  logic [31:0] op_ex_rs2_val;
  logic [31:0] op_ex_imm;
  logic [4:0]  op_ex_rs1;
  logic [4:0]  op_ex_rs2;
  logic [4:0]  op_ex_rd;
  alu_op_e     op_ex_alu_op;
  logic        op_ex_alu_src_imm;
  logic        op_ex_alu_src_pc;
  logic        op_ex_mem_rd;
  logic        op_ex_mem_wr;
  logic [2:0]  op_ex_funct3;
  logic        op_ex_reg_wr;
  logic        op_ex_branch;
  logic        op_ex_jal;
  logic        op_ex_jalr;
  logic        op_ex_illegal;

  modport master (
    output op_ex_valid, op_ex_pc, op_ex_rs1_val, op_ex_rs2_val, op_ex_imm,
           op_ex_rs1, op_ex_rs2, op_ex_rd, op_ex_alu_op, op_ex_alu_src_imm,
           op_ex_alu_src_pc, op_ex_mem_rd, op_ex_mem_wr, op_ex_funct3,
           op_ex_reg_wr, op_ex_branch, op_ex_jal, op_ex_jalr, op_ex_illegal
  );

  modport slave (
    input op_ex_valid, op_ex_pc, op_ex_rs1_val, op_ex_rs2_val, op_ex_imm,
          op_ex_rs1, op_ex_rs2, op_ex_rd, op_ex_alu_op, op_ex_alu_src_imm,
          op_ex_alu_src_pc, op_ex_mem_rd, op_ex_mem_wr, op_ex_funct3,
          op_ex_reg_wr, op_ex_branch, op_ex_jal, op_ex_jalr, op_ex_illegal
  );

endinterface

// File: rtl/jala_regfile.sv
// rtl/jala_regfile.sv - 32x32 architectural register file, 2 read / 1 write, x0 hardwired to zero.
// ID_RF_BYPASS_EN: a read of the register being written this cycle returns the write data.
module jala_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0][31:0] mem_q;
  logic [31:0][31:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != 5'd0)) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rdata1 = (raddr1 == 5'd0) ? 32'd0 : mem_q[raddr1];
    rdata2 = (raddr2 == 5'd0) ? 32'd0 : mem_q[raddr2];
`ifdef ID_RF_BYPASS_EN
    if (we && (waddr != 5'd0) && (waddr == raddr1)) rdata1 = wdata;
    if (we && (waddr != 5'd0) && (waddr == raddr2)) rdata2 = wdata;
`endif
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - Jala decode stage: IF/ID register, decode, regfile read, load-use stall, ID/EX register.
// ID_RF_BYPASS_EN selects regfile write-through instead of a one-cycle stall on a same-cycle writeback.
module id_stage
  import jala_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ip_if_valid,
  input  logic [31:0]       ip_if_pc,
  input  logic [31:0]       ip_if_inst,
  input  logic              ip_flush,
  input  logic              ip_wb_en,
  input  logic [4:0]        ip_wb_rd,
  input  logic [31:0]       ip_wb_data,
  output logic              op_stall,
  id_stage_if.master        ex
);

  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  id_ex_t      id_ex_q, id_ex_d;

  id_ex_t      dec;
  logic        uses_rs1, uses_rs2;
  logic        stall_raw;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rs1, rs2;
  logic [31:0] inst;

  assign inst = ifid_inst_q;
  assign rs1  = inst[19:15];
  assign rs2  = inst[24:20];

  jala_regfile u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (ip_wb_en),
    .waddr  (ip_wb_rd),
    .wdata  (ip_wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  always_comb begin
    dec             = '0;
    dec.valid       = 1'b1;
    dec.pc          = ifid_pc_q;
    dec.rs1         = rs1;
    dec.rs2         = rs2;
    dec.rd          = inst[11:7];
    dec.rs1_val     = rs1_val;
    dec.rs2_val     = rs2_val;
    dec.funct3      = inst[14:12];
    dec.alu_op      = ALU_ADD;
    uses_rs1        = 1'b1;
    uses_rs2        = 1'b0;
    case (inst[6:0])
      OPC_LUI: begin
        dec.imm = imm_u(inst); dec.alu_op = ALU_PASS_B; dec.alu_src_imm = 1'b1;
        dec.reg_wr = 1'b1; uses_rs1 = 1'b0;
      end
      OPC_AUIPC: begin
        dec.imm = imm_u(inst); dec.alu_src_imm = 1'b1; dec.alu_src_pc = 1'b1;
        dec.reg_wr = 1'b1; uses_rs1 = 1'b0;
      end
      OPC_JAL: begin
        dec.imm = imm_j(inst); dec.jal = 1'b1; dec.reg_wr = 1'b1; uses_rs1 = 1'b0;
      end
      OPC_JALR: begin
        dec.imm = imm_i(inst); dec.jalr = 1'b1; dec.alu_src_imm = 1'b1; dec.reg_wr = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b(inst); dec.branch = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        dec.imm = imm_i(inst); dec.mem_rd = 1'b1; dec.alu_src_imm = 1'b1; dec.reg_wr = 1'b1;
      end
      OPC_STORE: begin
        dec.imm = imm_s(inst); dec.mem_wr = 1'b1; dec.alu_src_imm = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.imm = imm_i(inst); dec.alu_src_imm = 1'b1;
        case (inst[14:12])
          3'b001:  dec.alu_op = ALU_SLL;
          3'b010:  dec.alu_op = ALU_SLT;
          3'b011:  dec.alu_op = ALU_SLTU;
          3'b100:  dec.alu_op = ALU_XOR;
          3'b101:  dec.alu_op = inst[30] ? ALU_SRA : ALU_SRL;
          3'b110:  dec.alu_op = ALU_OR;
          3'b111:  dec.alu_op = ALU_AND;
          default: dec.alu_op = ALU_ADD;
        endcase
        // Shift immediates only have a 5-bit shamt; bit 25 set would be a 64-bit shift.
        dec.illegal = (inst[13:12] == 2'b01) && inst[25];
        dec.reg_wr  = !dec.illegal;
      end
      OPC_OP: begin
        dec.reg_wr = 1'b1; uses_rs2 = 1'b1;
        case (inst[14:12])
          3'b000:  dec.alu_op = inst[30] ? ALU_SUB : ALU_ADD;
          3'b001:  dec.alu_op = ALU_SLL;
          3'b010:  dec.alu_op = ALU_SLT;
          3'b011:  dec.alu_op = ALU_SLTU;
          3'b100:  dec.alu_op = ALU_XOR;
          3'b101:  dec.alu_op = inst[30] ? ALU_SRA : ALU_SRL;
          3'b110:  dec.alu_op = ALU_OR;
          default: dec.alu_op = ALU_AND;
        endcase
      end
      OPC_MISC_MEM: begin
        dec.imm = '0;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    stall_raw = ifid_valid_q && id_ex_q.valid && id_ex_q.mem_rd && (id_ex_q.rd != 5'd0) &&
                ((uses_rs1 && (rs1 == id_ex_q.rd)) || (uses_rs2 && (rs2 == id_ex_q.rd)));
`ifndef ID_RF_BYPASS_EN
    // Without write-through the read would see the stale value; wait for the write to land.
    if (ifid_valid_q && ip_wb_en && (ip_wb_rd != 5'd0) &&
        ((uses_rs1 && (rs1 == ip_wb_rd)) || (uses_rs2 && (rs2 == ip_wb_rd)))) begin
      stall_raw = 1'b1;
    end
`endif
  end

  assign op_stall = stall_raw && !ip_flush;

  always_comb begin
    ifid_valid_d = ip_if_valid;
    ifid_pc_d    = ip_if_pc;
    ifid_inst_d  = ip_if_inst;
    id_ex_d      = '0;
    if (ip_flush) begin
      id_ex_d = '0;
    end else if (stall_raw) begin
      ifid_valid_d = ifid_valid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_inst_d  = ifid_inst_q;
    end else if (ifid_valid_q) begin
      id_ex_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'd0;
      ifid_inst_q  <= NOP_INST;
      id_ex_q      <= '0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      id_ex_q      <= id_ex_d;
    end
  end

  assign ex.op_ex_valid       = id_ex_q.valid;
  assign ex.op_ex_pc          = id_ex_q.pc;
  assign ex.op_ex_rs1_val     = id_ex_q.rs1_val;
  assign ex.op_ex_rs2_val     = id_ex_q.rs2_val;
  assign ex.op_ex_imm         = id_ex_q.imm;
  assign ex.op_ex_rs1         = id_ex_q.rs1;
  assign ex.op_ex_rs2         = id_ex_q.rs2;
  assign ex.op_ex_rd          = id_ex_q.rd;
  assign ex.op_ex_alu_op      = id_ex_q.alu_op;
  assign ex.op_ex_alu_src_imm = id_ex_q.alu_src_imm;
  assign ex.op_ex_alu_src_pc  = id_ex_q.alu_src_pc;
  assign ex.op_ex_mem_rd      = id_ex_q.mem_rd;
  assign ex.op_ex_mem_wr      = id_ex_q.mem_wr;
  assign ex.op_ex_funct3      = id_ex_q.funct3;
  assign ex.op_ex_reg_wr      = id_ex_q.reg_wr;
  assign ex.op_ex_branch      = id_ex_q.branch;
  assign ex.op_ex_jal         = id_ex_q.jal;
  assign ex.op_ex_jalr        = id_ex_q.jalr;
  assign ex.op_ex_illegal     = id_ex_q.illegal;

endmodule
